// File: rtl/ms_stopwatch_if.sv
// rtl/ms_stopwatch_if.sv - tick input, command pulses and display outputs of the stopwatch
interface ms_stopwatch_if;
  logic       tick_in;
  logic       start_stop;
  logic       clear;
  logic [9:0] ms_cnt;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic       running;
  logic       overflow;
  logic       sec_pulse;

  // Controller side: drives the tick and commands, observes the display values
  modport master (
    output tick_in, start_stop, clear,
    input  ms_cnt, sec_bcd, min_bcd, running, overflow, sec_pulse
  );

  // Stopwatch side
  modport slave (
    input  tick_in, start_stop, clear,
    output ms_cnt, sec_bcd, min_bcd, running, overflow, sec_pulse
  );
endinterface

// File: rtl/ms_stopwatch.sv
// rtl/ms_stopwatch.sv - millisecond tick synchroniser and mm:ss.ms stopwatch with overflow halt
module ms_stopwatch #(
  parameter int MS_PER_SEC = 1000, // legal range 2..1023
  parameter int MAX_MIN    = 99    // legal range 0..99
) (
  input logic           clk,
  input logic           rst_n,
  ms_stopwatch_if.slave sw
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, HALT} state_t;

  localparam logic [9:0] MS_LAST     = 10'(MS_PER_SEC - 1);
  localparam logic [7:0] MAX_MIN_BCD = 8'(((MAX_MIN / 10) << 4) | (MAX_MIN % 10));

  state_t     state_q, state_d;
  logic       s1_q, s2_q, s3_q;
  logic [9:0] ms_q, ms_d;
  logic [7:0] sec_q, sec_d;
  logic [7:0] min_q, min_d;
  logic       sec_pulse_q, sec_pulse_d;
  logic       tick;
  logic       at_max;

  // Three-flop chain: two for metastability, the third for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sw.tick_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick   = s2_q & ~s3_q;
  assign at_max = (ms_q == MS_LAST) && (sec_q == 8'h59) && (min_q == MAX_MIN_BCD);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Counter and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_q        <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      sec_pulse_q <= 1'b0;
    end else begin
      ms_q        <= ms_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      sec_pulse_q <= sec_pulse_d;
    end
  end

  // Next state and counter chain; counting uses the pre-transition state, clear wins over all
  always_comb begin
    state_d     = state_q;
    ms_d        = ms_q;
    sec_d       = sec_q;
    min_d       = min_q;
    sec_pulse_d = 1'b0;

    if (sw.clear) begin
      state_d = IDLE;
      ms_d    = '0;
      sec_d   = '0;
      min_d   = '0;
    end else begin
      if (state_q == RUN && tick) begin
        if (at_max) begin
          // Saturate rather than wrap: display freezes at full scale
          state_d = HALT;
        end else if (ms_q == MS_LAST) begin
          ms_d        = '0;
          sec_pulse_d = 1'b1;
          if (sec_q[3:0] == 4'd9) begin
            if (sec_q[7:4] == 4'd5) begin
              sec_d = '0;
              if (min_q[3:0] == 4'd9) min_d = {min_q[7:4] + 4'd1, 4'd0};
              else                    min_d = {min_q[7:4], min_q[3:0] + 4'd1};
            end else begin
              sec_d = {sec_q[7:4] + 4'd1, 4'd0};
            end
          end else begin
            sec_d = {sec_q[7:4], sec_q[3:0] + 4'd1};
          end
        end else begin
          ms_d = ms_q + 10'd1;
        end
      end

      // A simultaneous overflow takes precedence over a pause request
      if (sw.start_stop && state_d != HALT) begin
        case (state_q)
          IDLE:    state_d = RUN;
          RUN:     state_d = PAUSE;
          PAUSE:   state_d = RUN;
          default: state_d = state_q;
        endcase
      end
    end
  end

  assign sw.ms_cnt    = ms_q;
  assign sw.sec_bcd   = sec_q;
  assign sw.min_bcd   = min_q;
  assign sw.sec_pulse = sec_pulse_q;
  assign sw.running   = (state_q == RUN);
  assign sw.overflow  = (state_q == HALT);

endmodule

// File: doc/ms_stopwatch.md
Name: ms_stopwatch

Overview:
- Downstream consumer of the 1 kHz divider output.
- Synchronises and edge-detects the divided 1 kHz square wave into a one-cycle millisecond tick in the system clock domain.
- Accumulates ticks into a minutes:seconds.milliseconds stopwatch, with start/stop, clear and overflow handling.
- Outputs feed display/LCD logic.

Parameters:
- MS_PER_SEC, 1000, ticks per second; reduced values are used in simulation only. Must be between 2 and 1023.
- MAX_MIN, 99, highest minute value before overflow. Must be no greater than 99.

Ports:
- clk  input  1  system clock (12 MHz).
- rst_n  input  1  reset.
- tick_in  input  1  1 kHz square wave from the clock divider; asynchronous to sampling, treated as a level.
- start_stop  input  1  single-cycle command pulse: run/pause toggle.
- clear  input  1  single-cycle command pulse: zero all counters and return to IDLE.
- ms_cnt  output  10  milliseconds, binary, 0..MS_PER_SEC-1.
- sec_bcd  output  8  seconds, two BCD digits, 00..59.
- min_bcd  output  8  minutes, two BCD digits, 00..MAX_MIN.
- running  output  1  high while state is RUN.
- overflow  output  1  high while state is HALT.
- sec_pulse  output  1  one-cycle pulse on every seconds increment.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst_n is asynchronous, active-low.
  - On reset: all outputs 0, all counters 0, synchroniser flops 0, state IDLE.
  - Reset asserted mid-count aborts immediately. On release the block sits in IDLE with zeros; there is no auto-restart.
- Tick generation:
  - Sync chain s1 <= tick_in, s2 <= s1, s3 <= s2; tick = s2 & ~s3.
  - Exactly one tick per rising edge of tick_in, however long tick_in stays high.
  - Latency: ms_cnt changes on the 3rd rising clk edge, counting the edge that first samples tick_in high as the 1st.
- State machine, states IDLE, RUN, PAUSE, HALT:
  - IDLE + start_stop -> RUN.
  - RUN + start_stop -> PAUSE.
  - PAUSE + start_stop -> RUN.
  - RUN + tick at MAX_MIN:59.(MS_PER_SEC-1) -> HALT.
  - HALT: start_stop ignored.
  - Any state + clear -> IDLE, all counters 0, sec_pulse 0.
  - clear has priority over start_stop and tick in the same cycle.
- Counting:
  - Occurs only when the registered state is RUN and tick=1, evaluated with the pre-transition state.
  - A tick coinciding with a RUN->PAUSE start_stop is counted.
  - A tick coinciding with IDLE/PAUSE->RUN is not counted.
- Counter chain:
  - ms_cnt increments; at MS_PER_SEC-1 it wraps to 0 and carries to seconds, and sec_pulse=1 on the same edge the seconds change.
  - sec_bcd: low digit wraps 9->0 with carry to the high digit; 59 wraps to 00 and carries to minutes.
  - min_bcd: BCD increment 00..MAX_MIN.
  - At the full value MAX_MIN:59.(MS_PER_SEC-1), the next counted tick does not wrap. All counters hold, state goes to HALT, overflow=1 and sec_pulse stays 0.
- Output timing:
  - All outputs are registered; no combinational path from inputs to outputs.
  - running and overflow reflect the registered state.

Test Plan:
- Reset: assert rst_n=0 mid-count with ms_cnt=37 -> all outputs 0 asynchronously. Release, apply ticks without start_stop -> counters stay 0.
- Basic count: MS_PER_SEC=1000, start_stop, then 1000 tick_in rising edges (period 16 clk) -> ms_cnt=0, sec_bcd=8'h01, exactly one sec_pulse. Check the first ms_cnt=1 lands on the 3rd clk edge after tick_in first sampled high.
- Wrap: MS_PER_SEC=4, start_stop, 240 ticks -> min_bcd=8'h01, sec_bcd=8'h00, ms_cnt=0. At 36 ticks -> sec_bcd=8'h09; at 40 ticks -> sec_bcd=8'h10.
- Overflow: MS_PER_SEC=4, MAX_MIN=2, run 720 ticks -> overflow=1, running=0, display holds 02:59.3. Further ticks and start_stop change nothing; clear -> IDLE, all zeros.
- Commands:
  - start_stop after 5 ticks -> PAUSE, ms_cnt frozen at 5 across 10 ticks; start_stop again resumes.
  - clear and start_stop in the same cycle -> IDLE, zeros.
  - start_stop coincident with a tick in RUN -> that tick is counted.
- Glitch immunity: tick_in held high for 100 clk -> ms_cnt increments by exactly 1.
